// File: rtl/oldest_ready_select.sv
// Age-ordered issue selector: picks the oldest ready entry from a head-rotated
// valid vector and holds it on a registered valid/ready grant port.
module oldest_ready_select #(
  parameter  int unsigned WIDTH = 5,
  localparam int unsigned DEPTH = 1 << WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [WIDTH-1:0]  head_i,
  input  logic [DEPTH-1:0]  search_valid_i,
  output logic              grant_valid_o,
  output logic [WIDTH-1:0]  grant_idx_o,
  output logic [WIDTH-1:0]  grant_age_o,
  input  logic              grant_ready_i,
  output logic [15:0]       issue_cnt_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state, state_nxt;
  logic               grant_valid_nxt;
  logic [WIDTH-1:0]   grant_idx_nxt, grant_age_nxt;
  logic               last_acc_valid, last_acc_valid_nxt;
  logic [WIDTH-1:0]   last_acc_idx, last_acc_idx_nxt;
  logic [CNT_W-1:0]   issue_cnt_nxt;

  logic               accept_c;
  logic [WIDTH-1:0]   grant_pos_c, last_pos_c;
  logic [DEPTH-1:0]   mask_c, masked_c;
  logic               cand_found_c;
  logic [WIDTH-1:0]   cand_age_c, cand_idx_c;

  assign accept_c    = grant_valid_o & grant_ready_i;
  // Positions of already-granted entries, rotated into the current head frame
  assign grant_pos_c = grant_idx_o - head_i;
  assign last_pos_c  = last_acc_idx - head_i;

  // Mask and lowest-set-bit search over the rotated vector
  always_comb begin
    mask_c = '0;
    if (grant_valid_o)  mask_c[grant_pos_c] = 1'b1;
    if (last_acc_valid) mask_c[last_pos_c]  = 1'b1;
    masked_c     = search_valid_i & ~mask_c;
    cand_found_c = |masked_c;
    cand_age_c   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (masked_c[i]) cand_age_c = WIDTH'(i);
    end
    cand_idx_c = head_i + cand_age_c;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt          = state;
    grant_valid_nxt    = grant_valid_o;
    grant_idx_nxt      = grant_idx_o;
    grant_age_nxt      = grant_age_o;
    last_acc_valid_nxt = accept_c;
    last_acc_idx_nxt   = accept_c ? grant_idx_o : last_acc_idx;
    issue_cnt_nxt      = issue_cnt_o + CNT_W'(accept_c);

    if (flush) begin
      state_nxt          = IDLE;
      grant_valid_nxt    = 1'b0;
      last_acc_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_found_c) begin
            state_nxt       = HOLD;
            grant_valid_nxt = 1'b1;
            grant_idx_nxt   = cand_idx_c;
            grant_age_nxt   = cand_age_c;
          end
        end
        HOLD: begin
          // No re-selection while the grant is stalled
          if (accept_c) begin
            if (cand_found_c) begin
              grant_idx_nxt = cand_idx_c;
              grant_age_nxt = cand_age_c;
            end else begin
              state_nxt       = IDLE;
              grant_valid_nxt = 1'b0;
            end
          end
        end
        default: begin
          state_nxt       = IDLE;
          grant_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      grant_valid_o  <= 1'b0;
      grant_idx_o    <= '0;
      grant_age_o    <= '0;
      last_acc_valid <= 1'b0;
      last_acc_idx   <= '0;
      issue_cnt_o    <= '0;
    end else begin
      state          <= state_nxt;
      grant_valid_o  <= grant_valid_nxt;
      grant_idx_o    <= grant_idx_nxt;
      grant_age_o    <= grant_age_nxt;
      last_acc_valid <= last_acc_valid_nxt;
      last_acc_idx   <= last_acc_idx_nxt;
      issue_cnt_o    <= issue_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_oldest_ready_select.sv
// Self-checking bench for oldest_ready_select: vector table, directed corner
// sequences and random traffic against an absolute-index reference model.
module tb_oldest_ready_select;

  localparam int W = 5;
  localparam int D = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [W-1:0]  head;
  logic [D-1:0]  sv;
  logic          ready;
  logic          grant_valid;
  logic [W-1:0]  grant_idx;
  logic [W-1:0]  grant_age;
  logic [15:0]   issue_cnt;

  int tests = 0;
  int fails = 0;

  // Reference state: granted entry, entry accepted last cycle, accept count
  bit m_valid, m_lvalid;
  int m_idx, m_age, m_lidx, m_cnt;

  oldest_ready_select dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .head_i        (head),
    .search_valid_i(sv),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx),
    .grant_age_o   (grant_age),
    .grant_ready_i (ready),
    .issue_cnt_o   (issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_lvalid = 0; m_idx = 0; m_age = 0; m_lidx = 0; m_cnt = 0;
  endtask

  // Oldest ready entry that is neither the held grant nor the last accepted one
  task automatic model_step();
    bit acc;
    int kf, idx;
    acc = m_valid && ready;
    kf = -1;
    for (int k = 0; k < D; k++) begin
      idx = (int'(head) + k) % D;
      if (sv[k] && !(m_valid && idx == m_idx) && !(m_lvalid && idx == m_lidx)) begin
        kf = k;
        break;
      end
    end
    if (acc) m_cnt = (m_cnt + 1) % 65536;
    if (acc) m_lidx = m_idx;
    m_lvalid = acc;
    if (flush) begin
      m_valid = 0; m_lvalid = 0;
    end else if (!m_valid || acc) begin
      if (kf >= 0) begin
        m_valid = 1; m_idx = (int'(head) + kf) % D; m_age = kf;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, int'(grant_valid), int'(m_valid));
    check({tag, "_cnt"}, int'(issue_cnt), m_cnt);
    if (m_valid) begin
      check({tag, "_idx"}, int'(grant_idx), m_idx);
      check({tag, "_age"}, int'(grant_age), m_age);
    end
  endtask

  task automatic set_in(input int h, input logic [D-1:0] v, input bit r, input bit f);
    head = W'(h); sv = v; ready = r; flush = f;
  endtask

  typedef struct {
    int           head;
    logic [D-1:0] sv;
    bit           ready;
    bit           flush;
    bit           ev;
    int           eidx;
    int           eage;
    int           ecnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{30, 32'h0000_0008, 0, 0, 1, 1, 3, 0};   // wrap: 30+3 -> 1
    tbl[1]  = '{30, 32'h0000_0001, 0, 0, 1, 1, 3, 0};   // stalled, no reselect
    tbl[2]  = '{0,  32'h0000_0005, 1, 0, 1, 0, 0, 1};
    tbl[3]  = '{0,  32'h0000_0005, 1, 0, 1, 2, 2, 2};   // idx 0 masked
    tbl[4]  = '{0,  32'h0000_0005, 1, 0, 0, 0, 0, 3};   // both masked
    tbl[5]  = '{0,  32'h0000_0000, 1, 0, 0, 0, 0, 3};   // empty
    tbl[6]  = '{5,  32'hFFFF_FFFF, 0, 0, 1, 5, 0, 3};   // full -> head
    tbl[7]  = '{5,  32'hFFFF_FFFF, 0, 1, 0, 0, 0, 3};   // flush
    tbl[8]  = '{12, 32'h0000_0030, 0, 0, 1, 16, 4, 3};
    tbl[9]  = '{20, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 4};   // accept during flush
    tbl[10] = '{20, 32'h0000_0001, 0, 0, 1, 20, 0, 4};

    rst_n = 1'b0;
    set_in(0, '0, 0, 0);
    model_reset();
    #3;
    check("reset_valid", int'(grant_valid), 0);
    check("reset_idx", int'(grant_idx), 0);
    check("reset_age", int'(grant_age), 0);
    check("reset_cnt", int'(issue_cnt), 0);
    #9 rst_n = 1'b1;

    // Vector table
    foreach (tbl[i]) begin
      set_in(tbl[i].head, tbl[i].sv, tbl[i].ready, tbl[i].flush);
      step();
      check($sformatf("vec%0d_valid", i), int'(grant_valid), int'(tbl[i].ev));
      check($sformatf("vec%0d_cnt", i), int'(issue_cnt), tbl[i].ecnt);
      if (tbl[i].ev) begin
        check($sformatf("vec%0d_idx", i), int'(grant_idx), tbl[i].eidx);
        check($sformatf("vec%0d_age", i), int'(grant_age), tbl[i].eage);
      end
    end

    // Backpressure: grant at 4 stays while entry 0 becomes ready
    set_in(0, '0, 0, 1);
    step();
    set_in(0, D'(1) << 4, 0, 0);
    step();
    check("bp_first_idx", int'(grant_idx), 4);
    sv = (D'(1) << 4) | D'(1);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_hold%0d_valid", c), int'(grant_valid), 1);
      check($sformatf("bp_hold%0d_idx", c), int'(grant_idx), 4);
    end
    ready = 1'b1;
    step();
    check("bp_accept_idx", int'(grant_idx), 0);
    check("bp_accept_cnt", int'(issue_cnt), 5);

    // Async reset mid-HOLD with grant at 7
    sv = D'(1) << 7;
    step();
    ready = 1'b0;
    step();
    check("rst_pre_idx", int'(grant_idx), 7);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_valid", int'(grant_valid), 0);
    check("rst_async_cnt", int'(issue_cnt), 0);
    #2 rst_n = 1'b1;

    // Counter wrap with back-to-back accepts on a full vector
    set_in(0, '1, 1, 0);
    step();
    for (int c = 0; c < 65535; c++) step();
    check("wrap_cnt_max", int'(issue_cnt), 65535);
    check("wrap_valid", int'(grant_valid), 1);
    step();
    check("wrap_cnt_zero", int'(issue_cnt), 0);
    check_model("wrap_model");

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      logic [D-1:0] v;
      v = D'($urandom) & D'($urandom);
      if ($urandom_range(0, 7) == 0) v = '0;
      set_in(int'($urandom_range(0, D - 1)), v,
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
